lsu: RTL and testbench

- Load/store unit sitting between execute (E) and writeback (W).
- Consumes the one-hot load/store info vectors, register-write info and effective address produced upstream by decode/execute.
- Issues a single memory transaction per instruction over a valid/ready request/response port, aligns and extends load data, and hands the result to W.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu.sv | 142 ++++++++++++++
 tb/tb_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between E and W: one memory transaction per instruction, load align/extend.
// Latency: non-mem 1 cycle; load 3 cycles with zero-wait memory; store 2 or 3 depending on STORE_RESP.
// Backpressure: one instruction in flight; m_ready_o only in IDLE; DONE holds until W_ready_i.
module lsu #(
    parameter int XLEN       = 64,
    parameter bit STORE_RESP = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            E_valid_i,
    output logic            m_ready_o,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [6:0]      load_info_i,
    input  logic [3:0]      store_info_i,
    input  logic [4:0]      rd_i,
    input  logic            wenReg_i,
    output logic            m_valid_o,
    input  logic            W_ready_i,
    output logic [4:0]      rd_o,
    output logic            wenReg_o,
    output logic [XLEN-1:0] result_o,
    output logic            misalign_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    output logic            mem_req_wen_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    output logic [7:0]      mem_req_wstrb_o,
    input  logic            mem_resp_valid_i,
    output logic            mem_resp_ready_o,
    input  logic [XLEN-1:0] mem_resp_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [6:0]      load_q;
    logic            is_store_q;
    logic [2:0]      off_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            wen_q, mis_q;
    logic [XLEN-1:0] req_addr_q, req_wdata_q;
    logic            req_wen_q;
    logic [7:0]      req_wstrb_q;

    logic [10:0]     ops;
    logic            op_b, op_h, op_w, op_d;
    logic            none, bad_align, go_mem, err, accept;
    logic [7:0]      strb_base;
    logic [XLEN-1:0] shifted, load_val;

    assign ops    = {load_info_i, store_info_i};
    assign op_b   = load_info_i[0] | load_info_i[4] | store_info_i[0];
    assign op_h   = load_info_i[1] | load_info_i[5] | store_info_i[1];
    assign op_w   = load_info_i[2] | load_info_i[6] | store_info_i[2];
    assign op_d   = load_info_i[3] | store_info_i[3];
    assign none   = (ops == 11'd0);
    assign bad_align = (op_h & addr_i[0]) | (op_w & (|addr_i[1:0])) | (op_d & (|addr_i[2:0]));
    // op_b is accepted at any offset, so it never contributes to bad_align
    assign go_mem = $onehot(ops) && !bad_align && (op_b | op_h | op_w | op_d);
    assign err    = !none && !go_mem;
    assign accept = (state_q == IDLE) && E_valid_i && !reset;

    assign strb_base = ({8{store_info_i[0]}} & 8'h01) | ({8{store_info_i[1]}} & 8'h03) |
                       ({8{store_info_i[2]}} & 8'h0F) | ({8{store_info_i[3]}} & 8'hFF);

    assign shifted = mem_resp_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_val = '0;
        if (load_q[0])      load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        else if (load_q[1]) load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        else if (load_q[2]) load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
        else if (load_q[3]) load_val = shifted;
        else if (load_q[4]) load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
        else if (load_q[5]) load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
        else if (load_q[6]) load_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (E_valid_i) state_d = go_mem ? REQ : DONE;
            REQ:  if (mem_req_ready_i) state_d = (!is_store_q || STORE_RESP) ? WAIT : DONE;
            WAIT: if (mem_resp_valid_i) state_d = DONE;
            DONE: if (W_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            load_q      <= '0;
            is_store_q  <= 1'b0;
            off_q       <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            mis_q       <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wen_q   <= 1'b0;
            req_wstrb_q <= '0;
        end else if (accept) begin
            load_q      <= load_info_i;
            is_store_q  <= |store_info_i;
            off_q       <= addr_i[2:0];
            result_q    <= none ? alu_result_i : '0;
            rd_q        <= rd_i;
            wen_q       <= wenReg_i && !err;
            mis_q       <= err;
            // Request fields stay zero for anything that will not reach REQ
            req_addr_q  <= go_mem ? {addr_i[XLEN-1:3], 3'b000} : '0;
            req_wen_q   <= go_mem && (|store_info_i);
            req_wdata_q <= (go_mem && (|store_info_i)) ? (wdata_i << {addr_i[2:0], 3'b000}) : '0;
            req_wstrb_q <= go_mem ? (strb_base << addr_i[2:0]) : '0;
        end else if (state_q == WAIT && mem_resp_valid_i) begin
            result_q <= is_store_q ? '0 : load_val;
        end
    end

    assign m_ready_o        = (state_q == IDLE) && !reset;
    assign m_valid_o        = (state_q == DONE) && !reset;
    assign mem_req_valid_o  = (state_q == REQ)  && !reset;
    assign mem_resp_ready_o = (state_q == WAIT) && !reset;

    assign result_o        = result_q;
    assign rd_o            = rd_q;
    assign wenReg_o        = wen_q;
    assign misalign_o      = mis_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wen_o   = req_wen_q;
    assign mem_req_wdata_o = req_wdata_q;
    assign mem_req_wstrb_o = req_wstrb_q;
endmodule

// File: tb/tb_lsu.sv
// Scoreboarded bench for lsu: directed instructions, zero-wait memory model, result/request monitors.
module tb_lsu;
    logic        clock = 1'b0;
    logic        reset;
    logic        E_valid_i, m_ready_o;
    logic [63:0] addr_i, wdata_i, alu_result_i;
    logic [6:0]  load_info_i;
    logic [3:0]  store_info_i;
    logic [4:0]  rd_i;
    logic        wenReg_i;
    logic        m_valid_o, W_ready_i;
    logic [4:0]  rd_o;
    logic        wenReg_o, misalign_o;
    logic [63:0] result_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [63:0] mem_req_addr_o, mem_req_wdata_o;
    logic        mem_req_wen_o;
    logic [7:0]  mem_req_wstrb_o;
    logic        mem_resp_valid_i, mem_resp_ready_o;
    logic [63:0] mem_resp_rdata_i;

    lsu #(.XLEN(64), .STORE_RESP(1'b1)) dut (
        .clock(clock), .reset(reset),
        .E_valid_i(E_valid_i), .m_ready_o(m_ready_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .alu_result_i(alu_result_i),
        .load_info_i(load_info_i), .store_info_i(store_info_i),
        .rd_i(rd_i), .wenReg_i(wenReg_i),
        .m_valid_o(m_valid_o), .W_ready_i(W_ready_i),
        .rd_o(rd_o), .wenReg_o(wenReg_o), .result_o(result_o), .misalign_o(misalign_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_rdata_i(mem_resp_rdata_i)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [63:0] res; logic [4:0] rd; logic wen; logic mis; } res_t;
    typedef struct packed { logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb; logic wen; } req_t;

    res_t res_q[$];
    req_t req_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [6:0] LB = 7'b0000001, LH = 7'b0000010, LW = 7'b0000100, LD = 7'b0001000,
                           LBU = 7'b0010000, LHU = 7'b0100000, LWU = 7'b1000000, L0 = 7'b0;
    localparam logic [3:0] SB = 4'b0001, SH = 4'b0010, SD = 4'b1000, S0 = 4'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Zero-wait memory: always ready, responds the cycle after a request handshake
    logic        resp_pend;
    logic [63:0] mem_rdata;
    assign mem_req_ready_i  = 1'b1;
    assign mem_resp_valid_i = resp_pend;
    assign mem_resp_rdata_i = mem_rdata;
    always @(posedge clock) begin
        if (reset) resp_pend <= 1'b0;
        else if (mem_req_valid_o && mem_req_ready_i) resp_pend <= 1'b1;
        else if (mem_resp_valid_i && mem_resp_ready_o) resp_pend <= 1'b0;
    end

    always @(negedge clock) begin
        if (m_valid_o && W_ready_i) begin
            chk("result expected", 64'(res_q.size() > 0), 64'd1);
            if (res_q.size() > 0) begin
                res_t e;
                e = res_q.pop_front();
                chk("result_o", result_o, e.res);
                chk("rd_o", 64'(rd_o), 64'(e.rd));
                chk("wenReg_o", 64'(wenReg_o), 64'(e.wen));
                chk("misalign_o", 64'(misalign_o), 64'(e.mis));
            end
        end
    end

    always @(negedge clock) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
            chk("request expected", 64'(req_q.size() > 0), 64'd1);
            if (req_q.size() > 0) begin
                req_t r;
                r = req_q.pop_front();
                chk("mem_req_addr_o", mem_req_addr_o, r.addr);
                chk("mem_req_wdata_o", mem_req_wdata_o, r.wdata);
                chk("mem_req_wstrb_o", 64'(mem_req_wstrb_o), 64'(r.wstrb));
                chk("mem_req_wen_o", 64'(mem_req_wen_o), 64'(r.wen));
            end
        end
    end

    task automatic issue(input string nm, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] alu, input logic [6:0] ld, input logic [3:0] st,
                         input logic [4:0] rd, input logic we, input logic [63:0] rdat,
                         input int lat, input int stall, input logic [63:0] hold_res);
        int n;
        @(posedge clock); #1;
        addr_i = a; wdata_i = wd; alu_result_i = alu; load_info_i = ld; store_info_i = st;
        rd_i = rd; wenReg_i = we; mem_rdata = rdat; E_valid_i = 1'b1;
        if (stall > 0) W_ready_i = 1'b0;
        @(posedge clock); #1;
        E_valid_i = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (!m_valid_o && n < 20);
        chk({nm, " latency"}, 64'(n), 64'(lat));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                chk({nm, " stall m_valid_o"}, 64'(m_valid_o), 64'd1);
                chk({nm, " stall result_o"}, result_o, hold_res);
                chk({nm, " stall m_ready_o"}, 64'(m_ready_o), 64'd0);
                @(negedge clock);
            end
            @(posedge clock); #1;
            W_ready_i = 1'b1;
            @(negedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        chk({nm, " m_ready_o after W handshake"}, 64'(m_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; E_valid_i = 1'b0; W_ready_i = 1'b1; addr_i = '0; wdata_i = '0;
        alu_result_i = '0; load_info_i = '0; store_info_i = '0; rd_i = '0; wenReg_i = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset m_ready_o", 64'(m_ready_o), 64'd1);
        chk("reset m_valid_o", 64'(m_valid_o), 64'd0);
        chk("reset mem_req_valid_o", 64'(mem_req_valid_o), 64'd0);
        chk("reset mem_resp_ready_o", 64'(mem_resp_ready_o), 64'd0);
        chk("reset result_o", result_o, 64'd0);
        chk("reset rd_o/wen/mis", {rd_o, wenReg_o, misalign_o}, 64'd0);
        chk("reset mem_req_addr_o", mem_req_addr_o, 64'd0);
        chk("reset mem_req_wstrb_o/wen", {mem_req_wstrb_o, mem_req_wen_o}, 64'd0);

        // lb: byte 3 = 0x80 sign-extends
        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1'b1, 1'b0});
        issue("lb", 64'h8000_0003, 64'd0, 64'd0, LB, S0, 5'd5, 1'b1, 64'h1122_3344_8055_6677, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'h0000_0000_0000_BEEF, 5'd6, 1'b1, 1'b0});
        issue("lhu", 64'h8000_0006, 64'd0, 64'd0, LHU, S0, 5'd6, 1'b1, 64'hBEEF_0000_0000_0000, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'h0000_0000_1234_0000, 8'h0C, 1'b1});
        res_q.push_back('{64'd0, 5'd7, 1'b0, 1'b0});
        issue("sh", 64'h8000_0002, 64'h1234, 64'd0, L0, SH, 5'd7, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 3, 0, 64'd0);

        res_q.push_back('{64'd0, 5'd8, 1'b0, 1'b1});
        issue("lw misaligned", 64'h8000_0002, 64'd0, 64'd0, LW, S0, 5'd8, 1'b1, 64'd0, 1, 0, 64'd0);

        res_q.push_back('{64'h42, 5'd9, 1'b1, 1'b0});
        issue("alu stall", 64'h0, 64'd0, 64'h42, L0, S0, 5'd9, 1'b1, 64'd0, 1, 5, 64'h42);

        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'hFFFF_FFFF_FFFF_8001, 5'd10, 1'b1, 1'b0});
        issue("lh", 64'h8000_0004, 64'd0, 64'd0, LH, S0, 5'd10, 1'b1, 64'h0000_8001_0000_0000, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'hFFFF_FFFF_89AB_CDEF, 5'd11, 1'b1, 1'b0});
        issue("lw", 64'h8000_0004, 64'd0, 64'd0, LW, S0, 5'd11, 1'b1, 64'h89AB_CDEF_0000_0000, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'h0000_0000_F000_0000, 5'd12, 1'b1, 1'b0});
        issue("lwu", 64'h8000_0004, 64'd0, 64'd0, LWU, S0, 5'd12, 1'b1, 64'hF000_0000_0000_0000, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'h0000_0000_0000_00F0, 5'd13, 1'b1, 1'b0});
        issue("lbu", 64'h8000_0001, 64'd0, 64'd0, LBU, S0, 5'd13, 1'b1, 64'h0000_0000_0000_F000, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0008, 64'd0, 8'h00, 1'b0});
        res_q.push_back('{64'h0123_4567_89AB_CDEF, 5'd14, 1'b1, 1'b0});
        issue("ld", 64'h8000_0008, 64'd0, 64'd0, LD, S0, 5'd14, 1'b1, 64'h0123_4567_89AB_CDEF, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0010, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 1'b1});
        res_q.push_back('{64'd0, 5'd0, 1'b0, 1'b0});
        issue("sd", 64'h8000_0010, 64'hCAFE_F00D_DEAD_BEEF, 64'd0, L0, SD, 5'd0, 1'b0, 64'h5555, 3, 0, 64'd0);

        req_q.push_back('{64'h8000_0000, 64'hAB00_0000_0000_0000, 8'h80, 1'b1});
        res_q.push_back('{64'd0, 5'd0, 1'b0, 1'b0});
        issue("sb", 64'h8000_0007, 64'h0000_0000_0000_00AB, 64'd0, L0, SB, 5'd0, 1'b0, 64'd0, 3, 0, 64'd0);

        res_q.push_back('{64'd0, 5'd15, 1'b0, 1'b1});
        issue("two-hot", 64'h8000_0000, 64'd0, 64'd0, LB, SB, 5'd15, 1'b1, 64'd0, 1, 0, 64'd0);

        res_q.push_back('{64'd0, 5'd16, 1'b0, 1'b1});
        issue("sd misaligned", 64'h8000_0004, 64'd0, 64'd0, L0, SD, 5'd16, 1'b0, 64'd0, 1, 0, 64'd0);

        // Reset in WAIT while the response arrives: it must be dropped and no result produced
        req_q.push_back('{64'h8000_0000, 64'd0, 8'h00, 1'b0});
        @(posedge clock); #1;
        addr_i = 64'h8000_0000; load_info_i = LD; store_info_i = S0; rd_i = 5'd17;
        wenReg_i = 1'b1; mem_rdata = 64'h7777; E_valid_i = 1'b1;
        @(posedge clock); #1 E_valid_i = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("reset-in-WAIT mem_resp_ready_o", 64'(mem_resp_ready_o), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("after reset m_ready_o", 64'(m_ready_o), 64'd1);
        chk("after reset mem_resp_ready_o", 64'(mem_resp_ready_o), 64'd0);
        chk("after reset mem_req_valid_o", 64'(mem_req_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("after reset m_valid_o", 64'(m_valid_o), 64'd0);
            @(negedge clock);
        end

        chk("results outstanding", 64'(res_q.size()), 64'd0);
        chk("requests outstanding", 64'(req_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
